avr_trace_fetch: RTL and testbench
==================================

Name: avr_trace_fetch

Overview:
- Capture stage that sits between the core's instruction fetch/issue port and the trace consumer, i.e. the disassembly logger.
- Watches each instruction word the core issues and assembles 1- or 2-word AVR instructions into trace records (address, opcode, second word, length).
- Buffers the records in a small FIFO with a valid/ready handshake toward the consumer.
- Counts records lost to overflow.

Parameters:
- PAW, 16, program memory word-address width.
- DEPTH, 8, trace FIFO depth in records (power of two, >=2).
- CNTW, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- trc_en  in  1  capture enable
- ifu_vld  in  1  instruction word issued this cycle
- ifu_adr  in  PAW  word address of the issued word
- ifu_dat  in  16  issued instruction word
- trc_vld  out  1  record available
- trc_rdy  in  1  consumer accepts record
- trc_adr  out  PAW  address of first word
- trc_op0  out  16  first opcode word
- trc_op1  out  16  second word (0x0000 when trc_len=0)
- trc_len  out  1  0 = 1-word instruction, 1 = 2-word instruction
- trc_err  out  1  record truncated (second word missing or discontinuous)
- trc_ovf  out  1  sticky overflow flag
- trc_drop  out  CNTW  saturating count of dropped records
- ovf_clr  in  1  clears trc_ovf and trc_drop

Behaviour:
- Reset: asynchronous, active-low, clock clk.
  - All outputs reset to 0: trc_vld=0, trc_adr/op0/op1=0, trc_len=0, trc_err=0, trc_ovf=0, trc_drop=0.
  - FIFO is empty; FSM is in FIRST.
- Two-word classification, on the word captured in FIRST:
  - lds: 1001_000x_xxxx_0000
  - sts: 1001_001x_xxxx_0000
  - jmp: 1001_010x_xxxx_110x
  - call: 1001_010x_xxxx_111x
  - Every other pattern, including undefined encodings, is a 1-word instruction.
- FSM FIRST:
  - ifu_vld & trc_en & 1-word → push {adr, dat, 0x0000, len=0, err=0}; stay in FIRST.
  - ifu_vld & trc_en & 2-word → latch adr/dat; go to SECOND.
- FSM SECOND:
  - ifu_vld & ifu_adr == latched_adr+1 (modulo 2^PAW, so 0xFFFF→0x0000 wraps) → push {latched, dat, len=1, err=0}; go to FIRST.
  - ifu_vld & discontinuous address → push {latched, 0x0000, len=0, err=1}. The same cycle's word is then classified as a FIRST word; a 1-word instruction needs a second push. Handle this with a one-entry pending register: the second record is pushed the following cycle, before any new word.
  - trc_en falling while in SECOND → discard the partial record (no push); go to FIRST.
- Latency:
  - Push occurs at the clock edge that samples the completing ifu_vld.
  - With an empty FIFO, trc_vld=1 in the next cycle.
  - Output fields are registered and stable while trc_vld & !trc_rdy.
- FIFO:
  - Pop on trc_vld & trc_rdy.
  - Push while full and no pop in the same cycle → record dropped; trc_ovf←1; trc_drop increments, saturating at 2^CNTW-1.
  - Push and pop in the same cycle while full → both happen; nothing is dropped.
  - Push and pop in the same cycle while empty → push only (no fall-through to the output in the same cycle).
- ovf_clr:
  - Clears trc_ovf/trc_drop at the next edge.
  - A drop coincident with ovf_clr wins: trc_ovf=1, trc_drop=1.
- trc_en low: ifu traffic is ignored; the FIFO still drains.

Decomposition:
- Package avr_trace_pkg, containing:
  - Typedef trace_rec_t {adr, op0, op1, len, err}.
  - Function is_two_word(bit [15:0]), reusable by the disassembler side.
  - Constants for the lds/sts/jmp/call masks.
- Sub-module avr_trace_fifo: generic synchronous FIFO of trace_rec_t with full/empty flags, DEPTH parameter, and registered output.

Test Plan:
- nop 0x0000 at adr 0x0010, FIFO empty, trc_rdy=1 → next cycle trc_vld=1, adr=0x0010, op0=0x0000, op1=0x0000, len=0, err=0.
- jmp 0x940C at 0x0020, then 0x1234 at 0x0021 → exactly one record: adr=0x0020, op0=0x940C, op1=0x1234, len=1. call 0x940E at 0xFFFF followed by 0x0000 at 0x0000 gives a len=1 record (wrap).
- sts 0x9300 at 0x0030, then ldi 0xE01F at 0x0040 → record 1: {0x0030, 0x9300, 0x0000, len=0, err=1}; record 2: {0x0040, 0xE01F, len=0, err=0}, in order.
- trc_rdy=0, nine 1-word pushes with DEPTH=8 → trc_ovf=1, trc_drop=1; the first 8 records drain intact. Pulse ovf_clr → both return to 0.
- Full FIFO with push and pop in the same cycle → trc_drop unchanged; occupancy stays 8.
- rst_n asserted low while in SECOND after 0x9000 → outputs 0 immediately; after release, the word 0x1234 at the next address is treated as a FIRST word (1-word record, err=0).

Source files
------------

// File: rtl/avr_trace_pkg.sv
// Shared types and AVR two-word opcode classification for the instruction trace path.
// The disassembler side can reuse is_two_word() for the same decode.
package avr_trace_pkg;

  localparam int TRC_PAW = 16;

  localparam logic [15:0] LDS_MASK  = 16'hFE0F;
  localparam logic [15:0] LDS_VAL   = 16'h9000;
  localparam logic [15:0] STS_MASK  = 16'hFE0F;
  localparam logic [15:0] STS_VAL   = 16'h9200;
  localparam logic [15:0] JMP_MASK  = 16'hFE0E;
  localparam logic [15:0] JMP_VAL   = 16'h940C;
  localparam logic [15:0] CALL_MASK = 16'hFE0E;
  localparam logic [15:0] CALL_VAL  = 16'h940E;

  typedef struct packed {
    logic [TRC_PAW-1:0] adr;
    logic [15:0]        op0;
    logic [15:0]        op1;
    logic               len;
    logic               err;
  } trace_rec_t;

  function automatic logic is_two_word(input bit [15:0] w);
    return ((w & LDS_MASK) == LDS_VAL) || ((w & STS_MASK) == STS_VAL) ||
           ((w & JMP_MASK) == JMP_VAL) || ((w & CALL_MASK) == CALL_VAL);
  endfunction

endpackage

// File: rtl/avr_trace_fifo.sv
// Synchronous FIFO of trace records. The head record is held in an output
// register, so a record pushed into an empty FIFO appears on the next cycle.
module avr_trace_fifo
  import avr_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  trace_rec_t din,
  input  logic       pop,
  output trace_rec_t dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  trace_rec_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]    count_reg, count_left, count_next;
  trace_rec_t     dout_reg, dout_next;
  logic           pop_ok, push_ok;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign dout  = dout_reg;

  always_comb begin
    pop_ok      = pop & ~empty;
    push_ok     = push & (~full | pop_ok);
    rd_ptr_next = rd_ptr_reg + AW'(pop_ok);
    count_left  = count_reg - (AW+1)'(pop_ok);
    count_next  = count_left + (AW+1)'(push_ok);
    // When the full slot is overwritten in a push+pop cycle, rd_ptr_next has
    // already moved past it, so the old data is never read back.
    dout_next   = dout_reg;
    if (count_left != '0)
      dout_next = mem[rd_ptr_next];
    else if (push_ok)
      dout_next = din;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push_ok);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      dout_reg   <= dout_next;
    end
  end

endmodule

// File: rtl/avr_trace_fetch.sv
// Assembles issued AVR instruction words into 1-/2-word trace records, buffers
// them for the disassembly logger and counts records lost to overflow.
module avr_trace_fetch
  import avr_trace_pkg::*;
#(
  parameter int PAW   = TRC_PAW,
  parameter int DEPTH = 8,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trc_en,
  input  logic            ifu_vld,
  input  logic [PAW-1:0]  ifu_adr,
  input  logic [15:0]     ifu_dat,
  output logic            trc_vld,
  input  logic            trc_rdy,
  output logic [PAW-1:0]  trc_adr,
  output logic [15:0]     trc_op0,
  output logic [15:0]     trc_op1,
  output logic            trc_len,
  output logic            trc_err,
  output logic            trc_ovf,
  output logic [CNTW-1:0] trc_drop,
  input  logic            ovf_clr
);
  typedef enum logic {FIRST, SECOND} state_t;

  state_t          state_reg, state_next;
  logic [PAW-1:0]  lat_adr_reg;
  logic [15:0]     lat_dat_reg;
  logic            latch;
  trace_rec_t      word_rec, rec_a, rec_b, push_rec, pend_reg, pend_next, head;
  logic            has_a, has_b, push, pend_vld_reg, pend_vld_next;
  logic            fifo_full, fifo_empty, pop, drop;
  logic            ovf_reg;
  logic [CNTW-1:0] drop_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FIRST;
      lat_adr_reg  <= '0;
      lat_dat_reg  <= '0;
      pend_vld_reg <= 1'b0;
      pend_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      pend_vld_reg <= pend_vld_next;
      pend_reg     <= pend_next;
      if (latch) begin
        lat_adr_reg <= ifu_adr;
        lat_dat_reg <= ifu_dat;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    latch        = 1'b0;
    has_a        = 1'b0;
    has_b        = 1'b0;
    rec_a        = '0;
    rec_b        = '0;
    word_rec     = '0;
    word_rec.adr = TRC_PAW'(ifu_adr);
    word_rec.op0 = ifu_dat;
    case (state_reg)
      FIRST: begin
        if (trc_en && ifu_vld) begin
          if (is_two_word(ifu_dat)) begin
            latch      = 1'b1;
            state_next = SECOND;
          end else begin
            has_a = 1'b1;
            rec_a = word_rec;
          end
        end
      end
      SECOND: begin
        if (!trc_en) begin
          state_next = FIRST;
        end else if (ifu_vld) begin
          has_a      = 1'b1;
          rec_a.adr  = TRC_PAW'(lat_adr_reg);
          rec_a.op0  = lat_dat_reg;
          state_next = FIRST;
          if (ifu_adr == lat_adr_reg + PAW'(1)) begin
            rec_a.op1 = ifu_dat;
            rec_a.len = 1'b1;
          end else begin
            rec_a.err = 1'b1;
            if (is_two_word(ifu_dat)) begin
              latch      = 1'b1;
              state_next = SECOND;
            end else begin
              has_b = 1'b1;
              rec_b = word_rec;
            end
          end
        end
      end
      default: state_next = FIRST;
    endcase
    // A pending record always goes first; it can only exist in FIRST, where at
    // most one new record is produced, so one pending slot is enough.
    if (pend_vld_reg) begin
      push          = 1'b1;
      push_rec      = pend_reg;
      pend_vld_next = has_a;
      pend_next     = rec_a;
    end else begin
      push          = has_a;
      push_rec      = rec_a;
      pend_vld_next = has_b;
      pend_next     = rec_b;
    end
  end

  assign pop  = trc_vld & trc_rdy;
  assign drop = push & fifo_full & ~pop;

  avr_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_rec),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg  <= 1'b0;
      drop_reg <= '0;
    end else if (drop) begin
      ovf_reg  <= 1'b1;
      drop_reg <= ovf_clr ? CNTW'(1) : ((&drop_reg) ? drop_reg : drop_reg + CNTW'(1));
    end else if (ovf_clr) begin
      ovf_reg  <= 1'b0;
      drop_reg <= '0;
    end
  end

  assign trc_vld  = ~fifo_empty;
  assign trc_adr  = head.adr[PAW-1:0];
  assign trc_op0  = head.op0;
  assign trc_op1  = head.op1;
  assign trc_len  = head.len;
  assign trc_err  = head.err;
  assign trc_ovf  = ovf_reg;
  assign trc_drop = drop_reg;

endmodule

// File: tb/tb_avr_trace_fetch.sv
// Directed and randomized bench for avr_trace_fetch against a record-level
// reference model (instruction pairing + FIFO queue + drop counter).
module tb_avr_trace_fetch;
  localparam int PAW = 16;
  localparam int DEPTH = 8;
  localparam int CNTW = 8;
  localparam int DROP_MAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            trc_en = 1'b0;
  logic            ifu_vld = 1'b0;
  logic [PAW-1:0]  ifu_adr = '0;
  logic [15:0]     ifu_dat = '0;
  logic            trc_rdy = 1'b0;
  logic            ovf_clr = 1'b0;
  logic            trc_vld, trc_len, trc_err, trc_ovf;
  logic [PAW-1:0]  trc_adr;
  logic [15:0]     trc_op0, trc_op1;
  logic [CNTW-1:0] trc_drop;

  always #5 clk = ~clk;

  avr_trace_fetch #(.PAW(PAW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .trc_en(trc_en), .ifu_vld(ifu_vld),
    .ifu_adr(ifu_adr), .ifu_dat(ifu_dat), .trc_vld(trc_vld), .trc_rdy(trc_rdy),
    .trc_adr(trc_adr), .trc_op0(trc_op0), .trc_op1(trc_op1), .trc_len(trc_len),
    .trc_err(trc_err), .trc_ovf(trc_ovf), .trc_drop(trc_drop), .ovf_clr(ovf_clr)
  );

  typedef struct packed {
    logic [15:0] adr;
    logic [15:0] op0;
    logic [15:0] op1;
    logic        len;
    logic        err;
  } rec_t;

  rec_t        fq[$];
  rec_t        pq[$];
  bit          have_first;
  logic [15:0] f_adr, f_dat;
  bit          m_ovf;
  int          m_drop;
  int          tests = 0;
  int          fails = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // lds/sts: 1001 00sx ... 0000 ; jmp/call: 1001 010x ... 11xx
  function automatic bit two_word(input logic [15:0] w);
    if (w[15:12] != 4'h9) return 1'b0;
    case (w[11:9])
      3'b000, 3'b001: return w[3:0] == 4'h0;
      3'b010:         return w[3:2] == 2'b11;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic rec_t mk(input logic [15:0] a, input logic [15:0] o0,
                              input logic [15:0] o1, input logic l, input logic e);
    rec_t r;
    r.adr = a; r.op0 = o0; r.op1 = o1; r.len = l; r.err = e;
    return r;
  endfunction

  task automatic model_reset();
    fq.delete();
    pq.delete();
    have_first = 1'b0;
    m_ovf = 1'b0;
    m_drop = 0;
  endtask

  task automatic model_first(input logic [15:0] a, input logic [15:0] d);
    if (two_word(d)) begin
      have_first = 1'b1;
      f_adr = a;
      f_dat = d;
    end else begin
      pq.push_back(mk(a, d, 16'h0000, 1'b0, 1'b0));
    end
  endtask

  // Effect of the upcoming clock edge on the model, from the current inputs.
  task automatic model_step();
    bit   dropped;
    rec_t r;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!trc_en) begin
      have_first = 1'b0;
    end else if (ifu_vld) begin
      if (!have_first) begin
        model_first(ifu_adr, ifu_dat);
      end else begin
        have_first = 1'b0;
        if (ifu_adr == 16'(f_adr + 16'd1)) begin
          pq.push_back(mk(f_adr, f_dat, ifu_dat, 1'b1, 1'b0));
        end else begin
          pq.push_back(mk(f_adr, f_dat, 16'h0000, 1'b0, 1'b1));
          model_first(ifu_adr, ifu_dat);
        end
      end
    end
    if (fq.size() != 0 && trc_rdy) begin
      r = fq.pop_front();
      $display("[TB] rec adr=%h op0=%h op1=%h len=%0d err=%0d", r.adr, r.op0, r.op1, r.len, r.err);
    end
    dropped = 1'b0;
    if (pq.size() != 0) begin
      r = pq.pop_front();
      if (fq.size() < DEPTH) fq.push_back(r);
      else dropped = 1'b1;
    end
    if (dropped) begin
      m_ovf = 1'b1;
      m_drop = ovf_clr ? 1 : ((m_drop < DROP_MAX) ? m_drop + 1 : DROP_MAX);
    end else if (ovf_clr) begin
      m_ovf = 1'b0;
      m_drop = 0;
    end
  endtask

  task automatic cycle();
    rec_t r;
    @(negedge clk);
    check_val("vld", trc_vld, fq.size() != 0);
    if (fq.size() != 0) begin
      r = fq[0];
      check_val("adr", trc_adr, r.adr);
      check_val("op0", trc_op0, r.op0);
      check_val("op1", trc_op1, r.op1);
      check_val("len", trc_len, r.len);
      check_val("err", trc_err, r.err);
    end
    check_val("ovf", trc_ovf, m_ovf);
    check_val("drop", trc_drop, m_drop);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ifu_vld = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] d);
    ifu_vld = 1'b1;
    ifu_adr = a;
    ifu_dat = d;
    cycle();
    ifu_vld = 1'b0;
  endtask

  initial begin
    int          n;
    logic [15:0] next_adr, w, rnd;

    model_reset();
    repeat (3) cycle();
    check_val("rst_vld", trc_vld, 0);
    check_val("rst_adr", trc_adr, 0);
    check_val("rst_op0", trc_op0, 0);
    check_val("rst_op1", trc_op1, 0);
    check_val("rst_lenerr", {trc_len, trc_err}, 0);
    check_val("rst_ovfdrop", {trc_ovf, trc_drop}, 0);
    rst_n = 1'b1;
    trc_en = 1'b1;
    trc_rdy = 1'b1;

    issue(16'h0010, 16'h0000);
    check_val("nop_vld", trc_vld, 1);
    check_val("nop_adr", trc_adr, 16'h0010);
    check_val("nop_fields", {trc_op0, trc_op1, trc_len, trc_err}, 0);
    idle(2);

    issue(16'h0020, 16'h940C);
    check_val("jmp_wait", trc_vld, 0);
    issue(16'h0021, 16'h1234);
    check_val("jmp_rec", {trc_adr, trc_op0, trc_op1}, {16'h0020, 16'h940C, 16'h1234});
    check_val("jmp_len", {trc_len, trc_err}, 2'b10);
    idle(2);

    issue(16'hFFFF, 16'h940E);
    issue(16'h0000, 16'h0000);
    check_val("call_wrap", {trc_adr, trc_op0, trc_len, trc_err}, {16'hFFFF, 16'h940E, 2'b10});
    idle(2);

    issue(16'h0030, 16'h9300);
    issue(16'h0040, 16'hE01F);
    check_val("sts_trunc", {trc_adr, trc_op0, trc_op1, trc_len, trc_err}, {16'h0030, 16'h9300, 16'h0000, 2'b01});
    idle(1);
    check_val("ldi_after", {trc_vld, trc_adr, trc_op0, trc_len, trc_err}, {1'b1, 16'h0040, 16'hE01F, 2'b00});
    idle(2);

    trc_rdy = 1'b0;
    for (int i = 0; i < 9; i++) issue(16'h0100 + 16'(i), 16'h2400 + 16'(i));
    check_val("ovf_set", {trc_ovf, trc_drop}, {1'b1, 8'd1});
    trc_rdy = 1'b1;
    issue(16'h0200, 16'h0000);
    check_val("full_pushpop", {trc_ovf, trc_drop}, {1'b1, 8'd1});
    n = 0;
    while (trc_vld && n < 20) begin
      idle(1);
      n++;
    end
    check_val("full_occ", n, 8);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check_val("ovf_clr", {trc_ovf, trc_drop}, 0);

    trc_rdy = 1'b0;
    for (int i = 0; i < 270; i++) issue(16'h1000 + 16'(i), 16'h0000);
    check_val("drop_sat", trc_drop, DROP_MAX);
    ovf_clr = 1'b1;
    issue(16'h2000, 16'h0000);
    ovf_clr = 1'b0;
    check_val("drop_vs_clr", {trc_ovf, trc_drop}, {1'b1, 8'd1});
    trc_rdy = 1'b1;
    idle(DEPTH + 2);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;

    issue(16'h0300, 16'h940C);
    trc_en = 1'b0;
    issue(16'h0301, 16'h1234);
    trc_en = 1'b1;
    issue(16'h0302, 16'h0000);
    check_val("en_discard", {trc_adr, trc_len, trc_err}, {16'h0302, 2'b00});
    idle(2);

    trc_rdy = 1'b0;
    issue(16'h0050, 16'h0000);
    issue(16'h0060, 16'h9000);
    rst_n = 1'b0;
    #1;
    check_val("arst_vld", trc_vld, 0);
    check_val("arst_out", {trc_adr, trc_op0, trc_op1, trc_len, trc_err}, 0);
    model_reset();
    idle(1);
    rst_n = 1'b1;
    trc_rdy = 1'b1;
    issue(16'h0061, 16'h1234);
    check_val("arst_first", {trc_vld, trc_adr, trc_op0, trc_len, trc_err}, {1'b1, 16'h0061, 16'h1234, 2'b00});
    idle(2);

    next_adr = 16'hFFF0;
    for (int i = 0; i < 1500; i++) begin
      trc_en  = ($urandom_range(0, 19) != 0);
      trc_rdy = ($urandom_range(0, 9) < 6);
      ovf_clr = ($urandom_range(0, 29) == 0);
      rnd = 16'($urandom);
      case ($urandom_range(0, 5))
        0: w = 16'h9000 | (rnd & 16'h01F0);
        1: w = 16'h9200 | (rnd & 16'h01F0);
        2: w = 16'h940C | (rnd & 16'h01F1);
        3: w = 16'h940E | (rnd & 16'h01F1);
        default: w = rnd;
      endcase
      if ($urandom_range(0, 7) == 0) next_adr = 16'($urandom);
      if ($urandom_range(0, 9) < 7) begin
        issue(next_adr, w);
        next_adr = next_adr + 16'd1;
      end else begin
        idle(1);
      end
    end
    trc_en = 1'b0;
    trc_rdy = 1'b1;
    ovf_clr = 1'b0;
    idle(DEPTH + 4);
    check_val("end_empty", trc_vld, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
